// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer: selects jump target, PC+1 or hold each cycle,
// runs the start/halt handshake and counts RUN cycles per program run.
module pc_fetch_ctrl #(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PC_W-1:0]  i_start_addr,
  input  logic             i_stall,
  input  logic             i_branch_en,
  input  logic             i_branch_taken,
  input  logic [PC_W-1:0]  i_jump,
  input  logic             i_halt,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_count
);

  // state | meaning
  // IDLE  | waiting for first Start after reset
  // RUN   | fetching; PC advances unless stalled, counter increments each edge
  // DONE  | program halted; PC and count held for readout until next Start
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cycle_count;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_cycle_count <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state       <= ST_RUN;
            r_pc          <= i_start_addr;
            r_cycle_count <= '0;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        ST_RUN: begin
          // Stalled and halting edges still count as RUN cycles
          if (r_cycle_count != CNT_MAX)
            r_cycle_count <= r_cycle_count + CNT_ONE;
          if (!i_stall) begin
            if (i_halt) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (i_branch_en && i_branch_taken) begin
              r_pc <= i_jump;
            end else begin
              r_pc <= r_pc + PC_ONE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc          = r_pc;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed steps push expected outputs,
// a monitor pops and compares on each falling edge or on an async-reset probe.
module tb_pc_fetch_ctrl;

  typedef struct packed {
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] start_addr = '0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] jump = '0;
  logic        halt = 1'b0;
  logic [11:0] pc;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  event  chk_ev;

  pc_fetch_ctrl #(.PC_W(12), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_start_addr   (start_addr),
    .i_stall        (stall),
    .i_branch_en    (branch_en),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_halt         (halt),
    .o_pc           (pc),
    .o_busy         (busy),
    .o_done         (done),
    .o_cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Monitor: compares every pending expectation against the current outputs
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk or chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (pc !== e.pc) begin
          errors++;
          $display("FAIL %s pc: got %0d expected %0d", n, pc, e.pc);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL %s busy: got %0b expected %0b", n, busy, e.busy);
        end
        checks++;
        if (done !== e.done) begin
          errors++;
          $display("FAIL %s done: got %0b expected %0b", n, done, e.done);
        end
        checks++;
        if (cycle_count !== e.cnt) begin
          errors++;
          $display("FAIL %s cycle_count: got %0d expected %0d", n, cycle_count, e.cnt);
        end
      end
    end
  end

  task automatic push_exp(input string n, input logic [11:0] p, input logic b,
                          input logic d, input logic [15:0] c);
    exp_t e;
    e.pc = p; e.busy = b; e.done = d; e.cnt = c;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Drive one cycle of inputs and expect the given outputs after the next rising edge
  task automatic step(input string n, input logic st, input logic [11:0] sa,
                      input logic sl, input logic be, input logic bt,
                      input logic [11:0] jp, input logic ht,
                      input logic [11:0] epc, input logic eb, input logic ed,
                      input logic [15:0] ec);
    @(negedge clk);
    #1;
    start = st; start_addr = sa; stall = sl; branch_en = be;
    branch_taken = bt; jump = jp; halt = ht;
    push_exp(n, epc, eb, ed, ec);
  endtask

  // Assert reset between edges and check outputs without any clock edge
  task automatic reset_pulse(input string n);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    push_exp(n, 12'd0, 1'b0, 1'b0, 16'd0);
    -> chk_ev;
    @(negedge clk);
    #1;
    push_exp({n, "_hold"}, 12'd0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    reset_pulse("reset");
    for (int i = 0; i < 5; i++)
      step("idle", 1'b0, 12'd77, 1'b1, 1'b1, 1'b1, 12'd99, 1'b1, 12'd0, 1'b0, 1'b0, 16'd0);

    step("sl_start", 1'b1, 12'd0, 0, 0, 0, 12'd0, 0, 12'd0, 1, 0, 16'd0);
    step("sl_pc1",   1'b0, 12'd0, 0, 0, 0, 12'd0, 0, 12'd1, 1, 0, 16'd1);
    step("sl_pc2",   1'b0, 12'd0, 0, 0, 0, 12'd0, 0, 12'd2, 1, 0, 16'd2);
    step("sl_pc3",   1'b0, 12'd0, 0, 0, 0, 12'd0, 0, 12'd3, 1, 0, 16'd3);
    step("sl_halt",  1'b0, 12'd0, 0, 0, 0, 12'd0, 1, 12'd3, 0, 1, 16'd4);
    step("sl_hold",  1'b0, 12'd9, 0, 1, 1, 12'd9, 0, 12'd3, 0, 1, 16'd4);

    step("br_start", 1'b1, 12'd5, 0, 0, 0, 12'd0,  0, 12'd5,  1, 0, 16'd0);
    step("br_taken", 1'b0, 12'd0, 0, 1, 1, 12'd47, 0, 12'd47, 1, 0, 16'd1);
    step("br_not",   1'b0, 12'd0, 0, 1, 0, 12'd75, 0, 12'd48, 1, 0, 16'd2);
    step("br_halt",  1'b0, 12'd0, 0, 0, 0, 12'd0,  1, 12'd48, 0, 1, 16'd3);

    step("stl_start", 1'b1, 12'd10, 0, 0, 0, 12'd0,  0, 12'd10, 1, 0, 16'd0);
    step("stl_1",     1'b0, 12'd0,  1, 1, 1, 12'd21, 1, 12'd10, 1, 0, 16'd1);
    step("stl_2",     1'b0, 12'd0,  1, 1, 1, 12'd21, 1, 12'd10, 1, 0, 16'd2);
    step("stl_halt",  1'b0, 12'd0,  0, 1, 1, 12'd21, 1, 12'd10, 0, 1, 16'd3);

    step("wr_start", 1'b1, 12'd4094, 0, 0, 0, 12'd0, 0, 12'd4094, 1, 0, 16'd0);
    step("wr_4095",  1'b0, 12'd0,    0, 0, 0, 12'd0, 0, 12'd4095, 1, 0, 16'd1);
    step("wr_0",     1'b0, 12'd0,    0, 0, 0, 12'd0, 0, 12'd0,    1, 0, 16'd2);
    step("wr_1",     1'b0, 12'd0,    0, 0, 0, 12'd0, 0, 12'd1,    1, 0, 16'd3);
    step("wr_halt",  1'b0, 12'd0,    0, 0, 0, 12'd0, 1, 12'd1,    0, 1, 16'd4);
    step("restart",  1'b1, 12'd103,  0, 0, 0, 12'd0, 0, 12'd103,  1, 0, 16'd0);

    step("run_start_ign", 1'b1, 12'd900, 0, 1, 1, 12'd59, 0, 12'd59, 1, 0, 16'd1);
    step("run_pc60",      1'b0, 12'd0,   0, 0, 0, 12'd0,  0, 12'd60, 1, 0, 16'd2);
    start = 1'b0;
    reset_pulse("reset_midrun");

    step("post_rst_start", 1'b1, 12'd7, 0, 0, 0, 12'd0, 0, 12'd7, 1, 0, 16'd0);
    step("post_rst_pc8",   1'b0, 12'd0, 0, 0, 0, 12'd0, 0, 12'd8, 1, 0, 16'd1);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-sequencing stage for the 9-bit processor. It sits directly downstream of the jump lookup table: each cycle it chooses the next instruction address from the LUT's 12-bit jump target, PC+1, or hold. It also runs the start/halt handshake with the testbench or top level, and counts execution cycles for each program run.

## Interface
- PC_W, 12: program counter / jump target width.
- CNT_W, 16: cycle counter width.

- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  level; begins a program run when sampled high in IDLE or DONE.
- StartAddr  in  PC_W  first instruction address, loaded on Start.
- Stall  in  1  freezes PC and branch/halt evaluation for the cycle.
- BranchEn  in  1  current instruction is a branch.
- BranchTaken  in  1  branch condition result from the ALU flags.
- Jump  in  PC_W  absolute target from the jump LUT, valid in the same cycle as BranchEn.
- Halt  in  1  current instruction is the end-of-program instruction.
- PC  out  PC_W  registered current instruction address.
- Busy  out  1  high while in RUN.
- Done  out  1  high while in DONE; sticky until next Start.
- CycleCount  out  CNT_W  rising edges spent in RUN for the current/last run.

## Operation
- States: IDLE, RUN, DONE. Busy = (state==RUN). Done = (state==DONE). Both are decoded from registered state.
- Reset (Reset low, any time, including mid-run):
  - State goes to IDLE immediately.
  - PC=0, CycleCount=0, Busy=0, Done=0.
  - These values hold while Reset is low.
- IDLE:
  - Start=1: PC<=StartAddr, CycleCount<=0, go to RUN.
  - Otherwise everything holds. All other inputs are ignored.
- RUN, per rising edge, priority highest first:
  1. Stall=1: PC holds; Halt, BranchEn and Jump are ignored.
  2. Halt=1: PC holds; go to DONE.
  3. BranchEn=1 and BranchTaken=1: PC<=Jump.
  4. Otherwise, including BranchEn=1 with BranchTaken=0: PC<=PC+1 modulo 2^PC_W. 4095 wraps to 0 with no flag.
- Start is ignored while in RUN.
- CycleCount in RUN:
  - Increments on every RUN edge, including stalled edges and the Halt edge.
  - Saturates at 2^CNT_W-1; it does not wrap.
- DONE:
  - PC and CycleCount hold for readout.
  - Start=1 restarts exactly as from IDLE: PC<=StartAddr, CycleCount<=0, go to RUN, Done drops.
- Jump is consumed combinationally at the deciding edge; no internal copy of the LUT is kept.

## Timing
- Start sampled at edge k: PC=StartAddr and Busy=1 after edge k.
- The first instruction's branch/halt inputs are evaluated at edge k+1.
- PC update latency: one edge from the deciding inputs.
- Halt sampled at edge h: Busy=0 and Done=1 after edge h. PC still shows the halting instruction's address.
- A program of N instructions with no stalls yields CycleCount=N when Done rises. Each stall cycle adds 1.
- Reset deassertion is not required to be synchronous to Clk internally. The first Start is honoured at the first rising edge with Reset high.
- No combinational path from any input to any output.

## Test plan
- Reset and idle:
  - Pulse Reset low mid-clock.
  - Required: PC=0, Busy=0, Done=0, CycleCount=0 immediately.
  - Hold Start=0 for 5 cycles; all outputs unchanged.
- Straight-line run:
  - Start with StartAddr=0, no branches, Halt asserted when PC=3.
  - Required: PC sequence 0,1,2,3; Done=1 with PC=3; CycleCount=4.
- Taken and not-taken branch:
  - At PC=5, BranchEn=1, BranchTaken=1, Jump=47: next PC=47.
  - At PC=47, BranchEn=1, BranchTaken=0, Jump=75: next PC=48.
- Stall precedence:
  - At PC=10, Stall=1 with Halt=1 and a taken branch to 21, held 2 cycles.
  - Required: PC stays 10, Busy=1, CycleCount +2.
  - Release Stall with Halt=1: DONE, PC=10.
- Wrap and restart:
  - StartAddr=4094, run 3 cycles: PC 4094,4095,0,1.
  - Halt, then Start with StartAddr=103 from DONE: Done=0, PC=103, CycleCount=0.
- Reset mid-run:
  - At PC=60 in RUN, drive Reset low.
  - Required: state IDLE, PC=0, Busy=0 without waiting for a clock edge.
